// File: rtl/vga_capture_if.sv
// Wishbone pipelined write port used by the frame-capture engine.
//   adr[31:0], dat_o[31:0], sel[3:0], we, cyc, stb : driven by the master
//   ack, stall                                     : driven by the slave
interface if_wb;
  logic [31:0] adr;
  logic [31:0] dat_o;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;
  logic        stall;

  modport master (
    output adr, dat_o, sel, we, cyc, stb,
    input  ack, stall
  );

  modport slave (
    input  adr, dat_o, sel, we, cyc, stb,
    output ack, stall
  );
endinterface

// File: rtl/vga_capture.sv
// Frame-capture engine: samples a VGA-style pixel stream, packs each active
// pixel into {8'h00, r, g, b} and writes one frame to memory over a
// pipelined Wishbone master port.
// Ports:
//   clk_i, rst_i (async, active-low)  clock / reset
//   enable                             level, arms and holds capture
//   pix_en, vs, hs, blank_n, r, g, b   video input (valid when pix_en)
//   outbus (if_wb.master)              memory write port
//   busy                               state is not idle
//   frame_done                         one-cycle pulse per committed frame
//   overflow                           sticky, a pixel was dropped
module vga_capture #(
  parameter logic [31:0] CAP_MEMBASE = 32'h0,
  parameter int          BPP         = 8,
  parameter int          FIFO_DEPTH  = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           enable,
  input  logic           pix_en,
  input  logic           vs,
  input  logic           hs,
  input  logic           blank_n,
  input  logic [BPP-1:0] r,
  input  logic [BPP-1:0] g,
  input  logic [BPP-1:0] b,
  if_wb.master           outbus,
  output logic           busy,
  output logic           frame_done,
  output logic           overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [OW-1:0] OUT_ONE = {{(OW-1){1'b0}}, 1'b1};
  localparam logic [OW-1:0] OUT_MAX = OW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    CS_IDLE    = 3'd0,
    CS_WAITVS  = 3'd1,
    CS_CAPTURE = 3'd2,
    CS_DRAIN   = 3'd3,
    CS_DONE    = 3'd4
  } state_t;

  state_t        r_state, w_state_nxt;
  logic          r_vs_d, r_en_d, r_complete, r_overflow;
  logic [31:0]   r_adr_cnt;
  logic [AW:0]   r_wr_ptr, r_rd_ptr;
  logic [OW-1:0] r_outstanding;
  logic [23:0]   r_mem [FIFO_DEPTH];

  logic w_vs_fall, w_en_rise, w_empty, w_full, w_stb, w_accept;
  logic w_push_req, w_push, w_drop;
  logic w_load_base, w_clr_ovf, w_set_cmp, w_clr_cmp;
  logic w_unused_hs;

  assign w_unused_hs = hs;

  // vs history only advances on strobed cycles, so sync edges are seen in pixel time
  assign w_vs_fall  = pix_en & r_vs_d & ~vs;
  assign w_en_rise  = enable & ~r_en_d;

  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                      (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  // Holding stb off at FIFO_DEPTH outstanding keeps the counter in range
  // even against a slave that never acks.
  assign w_stb      = ~w_empty & (r_outstanding != OUT_MAX);
  assign w_accept   = w_stb & ~outbus.stall;

  // A full FIFO still takes a pixel when the head leaves in the same cycle
  assign w_push_req = (r_state == CS_CAPTURE) & pix_en & blank_n;
  assign w_push     = w_push_req & (~w_full | w_accept);
  assign w_drop     = w_push_req & w_full & ~w_accept;

  // Next-state and control strobes for the capture sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_load_base = 1'b0;
    w_clr_ovf   = 1'b0;
    w_set_cmp   = 1'b0;
    w_clr_cmp   = 1'b0;
    case (r_state)
      CS_IDLE: begin
        if (w_en_rise) begin
          w_state_nxt = CS_WAITVS;
          w_load_base = 1'b1;
          w_clr_ovf   = 1'b1;
        end else begin
          w_state_nxt = CS_IDLE;
        end
      end
      CS_WAITVS: begin
        if (!enable) begin
          w_state_nxt = CS_IDLE;
        end else if (w_vs_fall) begin
          w_state_nxt = CS_CAPTURE;
        end else begin
          w_state_nxt = CS_WAITVS;
        end
      end
      CS_CAPTURE: begin
        if (!enable) begin
          w_state_nxt = CS_DRAIN;
          w_clr_cmp   = 1'b1;
        end else if (w_vs_fall) begin
          w_state_nxt = CS_DRAIN;
          w_set_cmp   = 1'b1;
        end else begin
          w_state_nxt = CS_CAPTURE;
        end
      end
      CS_DRAIN: begin
        if (w_empty && (r_outstanding == {OW{1'b0}})) begin
          w_state_nxt = r_complete ? CS_DONE : CS_IDLE;
        end else begin
          w_state_nxt = CS_DRAIN;
        end
      end
      CS_DONE: begin
        if (enable) begin
          w_state_nxt = CS_WAITVS;
          w_load_base = 1'b1;
        end else begin
          w_state_nxt = CS_IDLE;
        end
      end
      default: begin
        w_state_nxt = CS_IDLE;
      end
    endcase
  end

  // State, sync/enable history, completion flag and sticky overflow
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state    <= CS_IDLE;
      r_vs_d     <= 1'b1;
      r_en_d     <= 1'b0;
      r_complete <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_en_d  <= enable;
      if (pix_en) r_vs_d <= vs;
      if (w_set_cmp)      r_complete <= 1'b1;
      else if (w_clr_cmp) r_complete <= 1'b0;
      if (w_clr_ovf)      r_overflow <= 1'b0;
      else if (w_drop)    r_overflow <= 1'b1;
    end
  end

  // Write address, FIFO pointers and outstanding-write counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_adr_cnt     <= CAP_MEMBASE;
      r_wr_ptr      <= {(AW+1){1'b0}};
      r_rd_ptr      <= {(AW+1){1'b0}};
      r_outstanding <= {OW{1'b0}};
    end else begin
      if (w_load_base)   r_adr_cnt <= CAP_MEMBASE;
      else if (w_accept) r_adr_cnt <= r_adr_cnt + 32'd4;
      if (w_push)   r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_accept) r_rd_ptr <= r_rd_ptr + PTR_ONE;
      if (w_accept && !outbus.ack) begin
        r_outstanding <= r_outstanding + OUT_ONE;
      end else if (!w_accept && outbus.ack && (r_outstanding != {OW{1'b0}})) begin
        r_outstanding <= r_outstanding - OUT_ONE;
      end
    end
  end

  // Pixel storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= {r[BPP-1-:8], g[BPP-1-:8], b[BPP-1-:8]};
  end

  assign outbus.stb   = w_stb;
  assign outbus.cyc   = w_stb | (r_outstanding != {OW{1'b0}});
  assign outbus.we    = 1'b1;
  assign outbus.sel   = 4'hF;
  assign outbus.adr   = r_adr_cnt;
  assign outbus.dat_o = {8'h00, r_mem[r_rd_ptr[AW-1:0]]};

  assign busy       = (r_state != CS_IDLE);
  assign frame_done = (r_state == CS_DONE);
  assign overflow   = r_overflow;
endmodule

// File: tb/tb_vga_capture.sv
`timescale 1ns/1ps
module tb_vga_capture;
  localparam int          BPP   = 8;
  localparam int          DEPTH = 16;
  localparam logic [31:0] BASE  = 32'h0;

  logic clk = 1'b0;
  logic rst_n, enable, pix_en, vs, hs, blank_n;
  logic [BPP-1:0] r, g, b;
  logic busy, frame_done, overflow;

  if_wb bus();

  vga_capture #(.CAP_MEMBASE(BASE), .BPP(BPP), .FIFO_DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_n), .enable(enable), .pix_en(pix_en),
    .vs(vs), .hs(hs), .blank_n(blank_n), .r(r), .g(g), .b(b),
    .outbus(bus.master), .busy(busy), .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state: expected write stream and occupancy bookkeeping
  logic [31:0] exp_q[$];
  int occ = 0, outst = 0, peak = 0, drops = 0, writes = 0, done_cnt = 0, widx = 0;
  bit cap_on = 1'b0, exp_ovf = 1'b0, en_prev = 1'b0, chk_idle = 1'b0;
  bit acc_now = 1'b0, acc, pushed;
  logic [31:0] first_dat, first_adr, last_adr, last_dat, px;
  int lat = 1;
  bit stall_force = 1'b0, rand_stall = 1'b0;
  logic [7:0] ack_pipe = 8'h00;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n) begin
      acc = bus.stb && !bus.stall;
      chk("stb", bus.stb, (occ != 0));
      chk("cyc", bus.cyc, ((occ != 0) || (outst != 0)));
      chk("overflow", overflow, exp_ovf);
      if (chk_idle) chk("busy_idle", busy, 1'b0);
      if (acc) begin
        chk("we_sel", {bus.we, bus.sel}, 5'h1F);
        chk("write_expected", (exp_q.size() != 0), 1'b1);
        if (exp_q.size() != 0) begin
          chk("adr", bus.adr, BASE + 32'(4 * widx));
          chk("dat", bus.dat_o, exp_q.pop_front());
        end
        if (widx == 0) begin
          first_dat = bus.dat_o;
          first_adr = bus.adr;
        end
        last_adr = bus.adr;
        last_dat = bus.dat_o;
        widx++;
        writes++;
      end
      if (frame_done) begin
        done_cnt++;
        chk("done_after_last_ack", outst, 0);
        chk("done_fifo_empty", occ, 0);
      end
      if (bus.ack) chk("ack_has_outstanding", (outst != 0 || acc), 1'b1);
      pushed = 1'b0;
      if (cap_on && pix_en && blank_n) begin
        px = {8'h00, r, g, b};
        if (occ < DEPTH || acc) begin
          exp_q.push_back(px);
          pushed = 1'b1;
        end else begin
          drops++;
          exp_ovf = 1'b1;
        end
      end
      if (enable && !en_prev) exp_ovf = 1'b0;
      en_prev = enable;
      occ = occ + int'(pushed) - int'(acc);
      outst = outst + int'(acc) - int'(bus.ack);
      if (outst > peak) peak = outst;
      acc_now = acc;
    end
  end

  // Wishbone slave: fixed ack latency, optional random or forced stall
  initial begin
    bus.ack = 1'b0;
    bus.stall = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) ack_pipe = 8'h00;
      else ack_pipe = {ack_pipe[6:0], acc_now};
      bus.ack = ack_pipe[lat-1];
      bus.stall = rand_stall ? ($urandom_range(0, 3) == 0) : stall_force;
    end
  end

  task automatic drive(input logic pe, input logic v, input logic h, input logic bn,
                       input logic [7:0] rr, input logic [7:0] gg, input logic [7:0] bb);
    pix_en = pe; vs = v; hs = h; blank_n = bn; r = rr; g = gg; b = bb;
    @(posedge clk); #1;
  endtask

  task automatic idle_drive();
    drive(1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'($urandom_range(0, 1)),
          8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic model_reset();
    exp_q.delete();
    occ = 0; outst = 0; widx = 0;
    cap_on = 1'b0; exp_ovf = 1'b0; en_prev = 1'b0; acc_now = 1'b0;
  endtask

  task automatic frame(input int w, input int h, input bit armed, input bit dense,
                       input bit fixed, input int abort_at, input int rst_at);
    int k = 0;
    logic [7:0] rr, gg, bb;
    widx = 0;
    repeat (3) drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    if (armed) cap_on = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (!dense) repeat ($urandom_range(0, 2)) idle_drive();
        if (k == abort_at) begin
          enable = 1'b0;
          drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
          cap_on = 1'b0;
          return;
        end
        if (k == rst_at) begin
          chk("rst_pre_cyc", bus.cyc, 1'b1);
          #2 rst_n = 1'b0;
          #1;
          chk("rst_async_cyc", bus.cyc, 1'b0);
          chk("rst_async_stb", bus.stb, 1'b0);
          chk("rst_async_busy", busy, 1'b0);
          model_reset();
          enable = 1'b0;
          repeat (3) @(posedge clk);
          #1 rst_n = 1'b1;
          return;
        end
        if (fixed) begin
          rr = 8'hAB; gg = 8'hCD; bb = 8'hEF + 8'(k);
        end else begin
          rr = 8'($urandom); gg = 8'($urandom); bb = 8'($urandom);
        end
        drive(1'b1, 1'b1, 1'b1, 1'b1, rr, gg, bb);
        k++;
      end
      repeat (2) drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
    cap_on = 1'b0;
    repeat (2) drive(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00);
  endtask

  task automatic wait_done(input int target, input int budget, input string nm);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      idle_drive();
      n++;
    end
    chk(nm, done_cnt, target);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin
      idle_drive();
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  task automatic start_capture();
    writes = 0; drops = 0; peak = 0;
    enable = 1'b1;
    idle_drive();
    chk("busy_after_enable", busy, 1'b1);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; enable = 1'b0; pix_en = 1'b0; vs = 1'b1; hs = 1'b1; blank_n = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_cyc", bus.cyc, 1'b0);
    chk("rst_stb", bus.stb, 1'b0);
    chk("rst_done", frame_done, 1'b0);
    chk("rst_ovf", overflow, 1'b0);
    chk("rst_adr", bus.adr, BASE);
    rst_n = 1'b1;

    // Live video with enable low: nothing happens
    chk_idle = 1'b1;
    frame(4, 2, 1'b0, 1'b0, 1'b0, -1, -1);
    repeat (5) idle_drive();
    chk_idle = 1'b0;
    chk("idle_no_writes", writes, 0);

    // 4x2 frame, known pixels, ack after one cycle
    lat = 1; stall_force = 1'b0; rand_stall = 1'b0;
    base = done_cnt;
    start_capture();
    frame(4, 2, 1'b1, 1'b1, 1'b1, -1, -1);
    wait_done(base + 1, 100, "t1_done");
    repeat (5) idle_drive();
    chk("t1_one_pulse", done_cnt, base + 1);
    chk("t1_writes", writes, 8);
    chk("t1_first_dat", first_dat, 32'h00ABCDEF);
    chk("t1_first_adr", first_adr, 32'h0000_0000);
    chk("t1_last_adr", last_adr, 32'h0000_001C);
    chk("t1_last_dat", last_dat, 32'h00ABCDF6);
    chk("t1_ovf", overflow, 1'b0);

    // Continuous capture: second frame, sparse pixels, random stall
    lat = 2; rand_stall = 1'b1; writes = 0;
    frame(5, 3, 1'b1, 1'b0, 1'b0, -1, -1);
    wait_done(base + 2, 200, "cont_done");
    chk("cont_writes", writes, 15);
    chk("cont_first_adr", first_adr, BASE);
    enable = 1'b0;
    wait_idle(50, "cont_idle");

    // Stall held while 20 back-to-back pixels arrive: 4 dropped
    lat = 1; rand_stall = 1'b0; stall_force = 1'b1;
    base = done_cnt;
    start_capture();
    frame(10, 2, 1'b1, 1'b1, 1'b0, -1, -1);
    repeat (8) idle_drive();
    chk("stall_drops", drops, 4);
    chk("stall_ovf", overflow, 1'b1);
    chk("stall_no_writes", writes, 0);
    stall_force = 1'b0;
    wait_done(base + 1, 200, "stall_done");
    chk("stall_writes", writes, 16);
    enable = 1'b0;
    wait_idle(50, "stall_idle");
    chk("ovf_held_in_idle", overflow, 1'b1);

    // Abort mid-frame: drain, no frame_done, then restart from base
    rand_stall = 1'b1; lat = 2;
    base = done_cnt;
    start_capture();
    chk("abort_ovf_cleared", overflow, 1'b0);
    frame(8, 3, 1'b1, 1'b0, 1'b0, 10, -1);
    wait_idle(200, "abort_busy_fall");
    repeat (3) idle_drive();
    chk("abort_no_done", done_cnt, base);
    chk("abort_writes", writes, 10);
    start_capture();
    frame(6, 2, 1'b1, 1'b0, 1'b0, -1, -1);
    wait_done(base + 1, 200, "reenable_done");
    chk("reenable_first_adr", first_adr, BASE);
    chk("reenable_writes", writes, 12);
    enable = 1'b0;
    wait_idle(50, "reenable_idle");

    // Ack latency 3 with back-to-back accepts
    lat = 3; rand_stall = 1'b0; stall_force = 1'b0;
    base = done_cnt;
    start_capture();
    frame(6, 2, 1'b1, 1'b1, 1'b0, -1, -1);
    wait_done(base + 1, 200, "lat3_done");
    chk("lat3_peak", peak, 3);
    chk("lat3_writes", writes, 12);
    enable = 1'b0;
    wait_idle(50, "lat3_idle");

    // Reset in the middle of a burst, then a clean capture
    base = done_cnt;
    start_capture();
    frame(8, 2, 1'b1, 1'b1, 1'b0, -1, 10);
    repeat (5) idle_drive();
    chk("rst_no_done", done_cnt, base);
    chk("rst_ovf_clear", overflow, 1'b0);
    lat = 1;
    start_capture();
    frame(4, 2, 1'b1, 1'b1, 1'b1, -1, -1);
    wait_done(base + 1, 100, "post_rst_done");
    chk("post_rst_first_adr", first_adr, BASE);
    chk("post_rst_first_dat", first_dat, 32'h00ABCDEF);
    chk("post_rst_writes", writes, 8);
    enable = 1'b0;
    wait_idle(50, "post_rst_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
